uart_rx: RTL and testbench

- Asynchronous serial receiver, 8N1, LSB first: start bit 0, data bits 0-7, stop bit 1.
- Consumes the serial line driven by the team's UART transmitter and delivers parallel bytes to downstream logic.
- Oversamples the line with an internal tick divider and samples each bit at mid-bit.
- Flags framing errors.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled, mid-bit sampling, framing error flag.
// Define UART_RX_PARITY_EN to add an even-parity bit and the perr pulse.
module uart_rx #(
  parameter int DIV = 4,
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxsd,
  output logic [7:0] rxpd,
  output logic       rxvalid,
  output logic       ferr,
  output logic       perr,
  output logic       busy,
  output logic [3:0] bcnt
);

  localparam int TW = $clog2(DIV);
  localparam int SW = $clog2(OVS);
  localparam logic [TW-1:0] TLAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SMID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SLAST = SW'(OVS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [3:0] BLAST = 4'd9;
`else
  localparam logic [3:0] BLAST = 4'd8;
`endif

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t state_q, state_d;
  logic rs1_q, rs2_q, rsp_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rxpd_q, rxpd_d;
  logic rxv_q, rxv_d;
  logic ferr_q, ferr_d;
  logic tick;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_q <= 1'b1;
      rs2_q <= 1'b1;
      rsp_q <= 1'b1;
    end else begin
      rs1_q <= rxsd;
      rs2_q <= rs1_q;
      rsp_q <= rs2_q;
    end
  end

  assign tick = (tcnt_q == TLAST);

  always_comb begin
    state_d = state_q;
    tcnt_d  = '0;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    rxpd_d  = rxpd_q;
    rxv_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (state_q != IDLE)
      tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        scnt_d = '0;
        bcnt_d = 4'd15;
        if (!rs2_q && rsp_q) begin
          state_d = START;
          bcnt_d  = 4'd0;
        end
      end
      START: if (tick) begin
        if (scnt_q == SMID) begin
          scnt_d = '0;
          if (!rs2_q) begin
            state_d = DATA;
            bcnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
            bcnt_d  = 4'd15;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (scnt_q == SLAST) begin
          scnt_d = '0;
          bcnt_d = bcnt_q + 4'd1;
`ifdef UART_RX_PARITY_EN
          if (bcnt_q == 4'd9) par_d = rs2_q;
          else sh_d = {rs2_q, sh_q[7:1]};
`else
          sh_d = {rs2_q, sh_q[7:1]};
`endif
          if (bcnt_q == BLAST) state_d = STOP;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        if (scnt_q == SLAST) begin
          state_d = IDLE;
          scnt_d  = '0;
          bcnt_d  = 4'd15;
          if (rs2_q) begin
            rxv_d  = 1'b1;
            rxpd_d = sh_q;
          end else begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_d = ^{sh_q, par_q};
`endif
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      bcnt_q  <= 4'd15;
      sh_q    <= '0;
      rxpd_q  <= '0;
      rxv_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      rxpd_q  <= rxpd_d;
      rxv_q   <= rxv_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rxpd    = rxpd_q;
  assign rxvalid = rxv_q;
  assign ferr    = ferr_q;
  assign busy    = (state_q != IDLE);
  assign bcnt    = bcnt_q;
`ifdef UART_RX_PARITY_EN
  assign perr    = perr_q;
`else
  assign perr    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames, back-to-back,
// glitch, framing error, reset abort, optional parity.
module tb_uart_rx;

  localparam int DIV = 4;
  localparam int OVS = 16;
  localparam int BIT = DIV * OVS;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxsd = 1'b1;
  logic [7:0] rxpd;
  logic       rxvalid, ferr, perr, busy;
  logic [3:0] bcnt;

  uart_rx #(.DIV(DIV), .OVS(OVS)) dut (
    .clk(clk), .rst(rst_n), .rxsd(rxsd),
    .rxpd(rxpd), .rxvalid(rxvalid), .ferr(ferr),
    .perr(perr), .busy(busy), .bcnt(bcnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int nv = 0, nf = 0, np = 0, ncoin = 0;
  logic [7:0] sb[$];
  int vtimes[$];
  logic [3:0] blog[$];
  logic [3:0] blast = 4'd15;
  bit log_en = 0;
`ifdef UART_RX_PARITY_EN
  bit bad_par = 0;
`endif

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rxvalid || ferr)
      check("vf_excl", {31'd0, rxvalid & ferr}, 32'd0);
    if (rxvalid) begin
      nv++;
      vtimes.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexp_valid", {24'd0, rxpd}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("rxpd", {24'd0, rxpd}, {24'd0, e});
      end
    end
    if (ferr) nf++;
    if (perr) np++;
    if (perr && rxvalid) ncoin++;
    if (log_en && bcnt != blast) blog.push_back(bcnt);
    blast = bcnt;
  end

  task automatic drive(input logic v, input int n);
    rxsd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    if (stop) sb.push_back(b);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive(^b ^ bad_par, BIT);
`endif
    drive(stop, BIT);
  endtask

  initial begin
    int v0, f0, p0, c0, gap;
    logic [3:0] ebc[$];
    repeat (3) @(negedge clk);
    check("rst_rxpd", {24'd0, rxpd}, 32'd0);
    check("rst_valid", {31'd0, rxvalid}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_perr", {31'd0, perr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bcnt", {28'd0, bcnt}, 32'd15);
    rst_n = 1'b1;
    drive(1'b1, BIT);

    // 1: single frame and bcnt trace
    v0 = nv; f0 = nf;
    blog.push_back(bcnt);
    log_en = 1;
    send(8'hA5, 1'b1);
    drive(1'b1, 2 * BIT);
    log_en = 0;
    check("t1_nvalid", nv - v0, 1);
    check("t1_ferr", nf - f0, 0);
    check("t1_rxpd", {24'd0, rxpd}, 32'hA5);
    check("t1_busy", {31'd0, busy}, 32'd0);
    ebc.push_back(4'd15);
    for (int i = 0; i <= FBITS - 1; i++)
      ebc.push_back(4'(i));
    ebc.push_back(4'd15);
    check("t1_bseq_len", blog.size(), ebc.size());
    for (int i = 0; i < ebc.size() && i < blog.size(); i++)
      check("t1_bseq", {28'd0, blog[i]}, {28'd0, ebc[i]});

    // 2: back-to-back frames
    v0 = nv;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    drive(1'b1, 2 * BIT);
    check("t2_nvalid", nv - v0, 2);
    if (vtimes.size() >= 2) begin
      gap = vtimes[$] - vtimes[$-1];
      check("t2_gap", (gap >= FBITS * BIT - 2 && gap <= FBITS * BIT + 2)
            ? FBITS * BIT : gap, FBITS * BIT);
    end
    check("t2_rxpd", {24'd0, rxpd}, 32'hFF);

    // 3: glitch shorter than half a bit
    v0 = nv; f0 = nf;
    drive(1'b0, 20);
    drive(1'b1, 2 * BIT);
    check("t3_bcnt", {28'd0, bcnt}, 32'd15);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_nvalid", nv - v0, 0);
    check("t3_nferr", nf - f0, 0);
    send(8'h3C, 1'b1);
    drive(1'b1, 2 * BIT);
    check("t3_rxpd", {24'd0, rxpd}, 32'h3C);

    // 4: framing error keeps previous byte
    send(8'h11, 1'b1);
    drive(1'b1, BIT);
    v0 = nv; f0 = nf;
    send(8'h3C, 1'b0);
    drive(1'b1, 2 * BIT);
    check("t4_nferr", nf - f0, 1);
    check("t4_nvalid", nv - v0, 0);
    check("t4_rxpd", {24'd0, rxpd}, 32'h11);
    send(8'h3C, 1'b1);
    drive(1'b1, 2 * BIT);
    check("t4_rxpd2", {24'd0, rxpd}, 32'h3C);

    // 5: reset during data bit 4 of 0x77
    v0 = nv; f0 = nf;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'b1 ^ (i == 3), BIT);
    drive(1'b1, BIT / 2);
    rst_n = 1'b0;
    #1;
    check("t5_rxpd", {24'd0, rxpd}, 32'd0);
    check("t5_bcnt", {28'd0, bcnt}, 32'd15);
    check("t5_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 12 * BIT);
    check("t5_nvalid", nv - v0, 0);
    check("t5_nferr", nf - f0, 0);
    send(8'h5A, 1'b1);
    drive(1'b1, 2 * BIT);
    check("t5_rxpd2", {24'd0, rxpd}, 32'h5A);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    v0 = nv; p0 = np; c0 = ncoin;
    send(8'h07, 1'b1);
    drive(1'b1, BIT);
    check("t6_nvalid", nv - v0, 1);
    check("t6_perr0", np - p0, 0);
    bad_par = 1;
    send(8'h07, 1'b1);
    drive(1'b1, BIT);
    bad_par = 0;
    check("t6_nvalid2", nv - v0, 2);
    check("t6_perr1", np - p0, 1);
    check("t6_coin", ncoin - c0, 1);
`else
    p0 = 0; c0 = 0;
    check("perr_none", np - p0, 0);
    check("coin_none", ncoin - c0, 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
